// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: one request per load/store, stalls the pipe
// until the data memory completes, sequences the dump/halt.
module mem_stage_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              createdump_is,
  input  logic              write_mem_is,
  input  logic              read_mem_is,
  input  logic              mem_to_reg_is,
  input  logic              reg_w_en_is,
  input  logic [DATA_W-1:0] data_2_is,
  input  logic [DATA_W-1:0] ALU_out_is,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_dump,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_busy,
  output logic              stall,
  output logic [DATA_W-1:0] mem_data_os,
  output logic [DATA_W-1:0] ALU_out_os,
  output logic              mem_to_reg_os,
  output logic              reg_w_en_os,
  output logic              halted,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HALT
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] rd_q;
  logic [15:0]       stall_cnt_q;
  logic              dump_pend_q;
  logic              dump_pend_d;
  logic              op;
  logic              is_rd;
  logic              done_now;

  assign op    = read_mem_is | write_mem_is;
  // both strobes set means a store, so nothing is captured
  assign is_rd = read_mem_is & ~write_mem_is;

  always_comb begin
    state_d     = state_q;
    dump_pend_d = dump_pend_q;
    mem_en      = 1'b0;
    mem_dump    = 1'b0;
    stall       = 1'b0;
    done_now    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (dump_pend_q || (createdump_is && !op)) begin
            mem_dump    = 1'b1;
            dump_pend_d = 1'b0;
            state_d     = HALT;
          end else if (op) begin
            mem_en = 1'b1;
            if (mem_busy) begin
              stall = 1'b1;
            end else if (mem_done) begin
              done_now    = 1'b1;
              dump_pend_d = createdump_is;
            end else begin
              stall   = 1'b1;
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          if (mem_done) begin
            done_now    = 1'b1;
            dump_pend_d = createdump_is;
            state_d     = IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        HALT: stall = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      dump_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dump_pend_q <= dump_pend_d;
      if (done_now && is_rd)
        rd_q <= mem_rdata;
      if (stall && state_q != HALT &&
          stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign mem_wr        = write_mem_is;
  assign mem_addr      = ALU_out_is;
  assign mem_wdata     = data_2_is;
  assign mem_data_os   = done_now ? mem_rdata : rd_q;
  assign ALU_out_os    = ALU_out_is;
  assign mem_to_reg_os = mem_to_reg_is;
  assign reg_w_en_os   = reg_w_en_is & ~stall & ~rst;
  assign halted        = (state_q == HALT);
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: vector table, hand sequences and
// randomized transactions against a transaction-level model.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cd, wr, rd, m2r, rwe;
  logic [15:0] d2, alu, rdata;
  logic        done, busy;

  logic        mem_en, mem_wr, mem_dump, stall;
  logic        mem_to_reg_os, reg_w_en_os, halted;
  logic [15:0] mem_addr, mem_wdata, mem_data_os;
  logic [15:0] ALU_out_os, stall_cnt;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] rd_m;
  logic [15:0] cnt_m;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DATA_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .createdump_is (cd),
    .write_mem_is  (wr),
    .read_mem_is   (rd),
    .mem_to_reg_is (m2r),
    .reg_w_en_is   (rwe),
    .data_2_is     (d2),
    .ALU_out_is    (alu),
    .mem_en        (mem_en),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_dump      (mem_dump),
    .mem_rdata     (rdata),
    .mem_done      (done),
    .mem_busy      (busy),
    .stall         (stall),
    .mem_data_os   (mem_data_os),
    .ALU_out_os    (ALU_out_os),
    .mem_to_reg_os (mem_to_reg_os),
    .reg_w_en_os   (reg_w_en_os),
    .halted        (halted),
    .stall_cnt     (stall_cnt)
  );

  typedef struct {
    logic        r, w, b, d;
    logic [15:0] rdata, alu, d2;
    logic        e_en, e_stall;
    logic [15:0] e_data;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // inputs already driven; compare mid-cycle, then advance one edge
  task automatic cyc(input logic e_en, e_stall, e_dump, e_halt,
                     input logic [15:0] e_data,
                     input string tag);
    #4;
    chk({tag, " mem_en"}, 16'(mem_en), 16'(e_en));
    if (e_en) chk({tag, " mem_wr"}, 16'(mem_wr), 16'(wr));
    chk({tag, " stall"}, 16'(stall), 16'(e_stall));
    chk({tag, " mem_dump"}, 16'(mem_dump), 16'(e_dump));
    chk({tag, " halted"}, 16'(halted), 16'(e_halt));
    chk({tag, " mem_data_os"}, mem_data_os, e_data);
    chk({tag, " reg_w_en_os"}, 16'(reg_w_en_os),
        16'(rwe & ~e_stall & ~rst));
    chk({tag, " mem_addr"}, mem_addr, alu);
    chk({tag, " mem_wdata"}, mem_wdata, d2);
    chk({tag, " ALU_out_os"}, ALU_out_os, alu);
    chk({tag, " mem_to_reg_os"}, 16'(mem_to_reg_os), 16'(m2r));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cd = 1'b0; wr = 1'b0; rd = 1'b0;
    busy = 1'b0; done = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_m = '0;
    cnt_m = '0;
  endtask

  // b busy cycles, then acceptance; done arrives n cycles later
  task automatic txn(input logic w, r,
                     input logic [15:0] a, d, fin,
                     input int b, n,
                     input logic c,
                     input string tag);
    bit last;
    wr = w; rd = r; alu = a; d2 = d; cd = c;
    m2r = 1'($urandom); rwe = 1'($urandom);
    for (int k = 0; k <= b + n; k++) begin
      last = (k == b + n);
      if (k < b) busy = 1'b1;
      else if (k == b) busy = 1'b0;
      else busy = 1'($urandom);
      if (k < b) done = 1'($urandom);
      else done = last;
      rdata = last ? fin : 16'($urandom);
      cyc(k <= b, !last, 1'b0, 1'b0,
          last ? rdata : rd_m, tag);
      if (last && r && !w) rd_m = rdata;
      if (!last && cnt_m != 16'hFFFF) cnt_m++;
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    rst = 1'b1; m2r = 1'b0; rwe = 1'b1;
    d2 = 16'h5A5A; alu = 16'h0100; rdata = 16'h0;
    @(posedge clk);
    #1;
    // reset held with an op present: everything quiet
    rd = 1'b1; done = 1'b1; rdata = 16'h1357;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "rst_hold");
    rst = 1'b0; idle_in(); rd_m = '0; cnt_m = '0;
    chk("rst stall_cnt", stall_cnt, 16'h0000);

    tv[0] = '{0,0,0,1,16'h1111,16'h0001,16'hAAAA,0,0,16'h0000};
    tv[1] = '{1,0,0,1,16'hBEEF,16'h0040,16'h0000,1,0,16'hBEEF};
    tv[2] = '{0,0,0,0,16'h2222,16'h0002,16'h0001,0,0,16'hBEEF};
    tv[3] = '{1,0,1,1,16'h5555,16'h0003,16'h0002,1,1,16'hBEEF};
    tv[4] = '{1,1,0,1,16'h7777,16'h0004,16'hCAFE,1,0,16'h7777};
    tv[5] = '{0,0,0,0,16'h3333,16'h0005,16'h0003,0,0,16'hBEEF};
    tv[6] = '{0,1,1,0,16'h4444,16'h0006,16'h0004,1,1,16'hBEEF};
    tv[7] = '{1,0,0,1,16'h0123,16'h0007,16'h0005,1,0,16'h0123};
    tv[8] = '{0,0,1,1,16'h9999,16'h0008,16'h0006,0,0,16'h0123};
    for (int i = 0; i < 9; i++) begin
      rd = tv[i].r; wr = tv[i].w;
      busy = tv[i].b; done = tv[i].d;
      rdata = tv[i].rdata; alu = tv[i].alu; d2 = tv[i].d2;
      rwe = 1'b1; m2r = 1'(i);
      cyc(tv[i].e_en, tv[i].e_stall, 1'b0, 1'b0,
          tv[i].e_data, $sformatf("vec%0d", i));
    end
    chk("vec stall_cnt", stall_cnt, 16'd2);

    do_reset();
    txn(0, 1, 16'h0040, 16'h0, 16'hBEEF, 0, 0, 0, "hit");
    chk("hit stall_cnt", stall_cnt, 16'd0);
    txn(1, 0, 16'h0010, 16'h1234, 16'h0, 0, 3, 0, "store3");
    chk("store3 stall_cnt", stall_cnt, 16'd3);
    txn(0, 1, 16'h0020, 16'h0, 16'hA5A5, 2, 0, 0, "retry");
    chk("retry stall_cnt", stall_cnt, 16'd5);

    txn(0, 1, 16'h0030, 16'h0, 16'hC0DE, 0, 2, 1, "dumpop");
    rwe = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'hC0DE, "dump_pulse");
    rd = 1'b1; done = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'hC0DE, "halt");
    chk("halt stall_cnt", stall_cnt, 16'd7);

    do_reset();
    cd = 1'b1; rwe = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, "dump_noop");
    cd = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, "halt2");

    do_reset();
    rd = 1'b1; alu = 16'h0044; rwe = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, "rb_issue");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "rb_busy1");
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "rb_rst");
    rst = 1'b0; rd = 1'b0; done = 1'b1; rdata = 16'hDEAD;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "rb_stray");
    chk("rb stall_cnt", stall_cnt, 16'd0);
    done = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "rb_after");

    do_reset();
    for (int t = 0; t < 150; t++) begin
      int kind, b, n, gap;
      kind = int'($urandom_range(0, 4));
      b = int'($urandom_range(0, 3));
      n = int'($urandom_range(0, 4));
      gap = int'($urandom_range(0, 2));
      txn(kind == 1 || kind == 2, kind != 1,
          16'($urandom), 16'($urandom), 16'($urandom),
          b, n, 1'b0, "rnd");
      chk("rnd stall_cnt", stall_cnt, cnt_m);
      for (int g = 0; g < gap; g++) begin
        busy = 1'($urandom); done = 1'($urandom);
        rdata = 16'($urandom); rwe = 1'($urandom);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, rd_m, "gap");
      end
    end

    do_reset();
    rd = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat fffe", stall_cnt, 16'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("sat ffff", stall_cnt, 16'hFFFF);
    done = 1'b1; rdata = 16'h4321;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h4321, "sat_done");
    chk("sat hold", stall_cnt, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller that consumes the EX/MEM pipeline register outputs and drives a multi-cycle data memory with a request/done handshake. It issues exactly one memory request per load/store, holds the pipeline through `stall` until the memory reports completion, and hands the result to the MEM/WB register. Bubbles are inserted toward write-back while a memory operation is stalled. It also sequences the `createdump` halt and keeps a stall-cycle counter.

## Interface
Parameters:
- `DATA_W`, 16, data and address width

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `createdump_is`  in  1  halt/dump request from EX/MEM
- `write_mem_is`  in  1  store from EX/MEM
- `read_mem_is`  in  1  load from EX/MEM
- `mem_to_reg_is`  in  1  WB mux select from EX/MEM
- `reg_w_en_is`  in  1  register write enable from EX/MEM
- `data_2_is`  in  DATA_W  store data
- `ALU_out_is`  in  DATA_W  address / ALU result
- `mem_en`  out  1  memory request strobe
- `mem_wr`  out  1  1 = write, 0 = read; valid with `mem_en`
- `mem_addr`  out  DATA_W  equals `ALU_out_is`
- `mem_wdata`  out  DATA_W  equals `data_2_is`
- `mem_dump`  out  1  one-cycle dump strobe to memory
- `mem_rdata`  in  DATA_W  read data; valid when `mem_done`
- `mem_done`  in  1  request complete (may arrive in the issue cycle)
- `mem_busy`  in  1  memory cannot accept `mem_en` this cycle
- `stall`  out  1  hold upstream pipeline registers (drives their `en` low)
- `mem_data_os`  out  DATA_W  load result to MEM/WB
- `ALU_out_os`  out  DATA_W  pass-through of `ALU_out_is`
- `mem_to_reg_os`  out  1  pass-through
- `reg_w_en_os`  out  1  `reg_w_en_is & ~stall`
- `halted`  out  1  sticky, set after the dump strobe
- `stall_cnt`  out  16  saturating count of stall cycles

## Operation
- FSM states: IDLE, BUSY, HALT.
- Define `op = read_mem_is | write_mem_is`.
- **IDLE, no op:**
  - `mem_en=0`, `stall=0`.
  - All data passes through.
- **IDLE with op:**
  - Drive `mem_en=1`, with `mem_wr=write_mem_is`.
  - If `mem_busy=1`: request not accepted; `stall=1`; remain IDLE; reissue next cycle.
  - Else if `mem_done=1` (same-cycle hit): `stall=0`, `mem_data_os=mem_rdata`; remain IDLE.
  - Else: `stall=1`; go to BUSY.
- **BUSY:**
  - `mem_en=0`. A request is never reissued.
  - `stall = ~mem_done`.
  - On `mem_done`: `mem_data_os=mem_rdata`, `stall=0`, go to IDLE. The EX/MEM register advances on that edge.
- **Dump:**
  - `createdump_is` with no op, in IDLE: pulse `mem_dump` for one cycle, then go to HALT.
  - `createdump_is` together with an op: the op completes first, then the dump pulses in the following IDLE cycle.
- **HALT:**
  - `halted=1`, `mem_en=0`, `mem_dump=0`, `stall=1`.
  - Exit only via `rst`.
- **`mem_data_os` outside a completion cycle:** holds the last captured read data (register `rd_q`, loaded on `mem_done & read_mem_is`).
- **`stall_cnt`:**
  - Increments by 1 on each clock edge where `stall=1` and state is not HALT.
  - Saturates at 0xFFFF.
- **Invalid input:** `write_mem_is` and `read_mem_is` both asserted is treated as a write.

## Timing
- Reset (at the clock edge with `rst=1`):
  - state = IDLE, `rd_q=0`, `stall_cnt=0`, `halted=0`.
  - Dump-pending flag cleared.
- While `rst=1`: `mem_en=0`, `mem_dump=0`, `stall=0`, `reg_w_en_os=0`.
- Latency:
  - Same-cycle hit: 0 stall cycles.
  - Otherwise: N stall cycles, where `mem_done` arrives N cycles after acceptance.
- `stall`, `mem_en`, `mem_addr`, `mem_wdata` and `mem_data_os` are combinational from state and inputs. No combinational path exists from `mem_done` to `mem_en`.
- `mem_busy` is sampled only in IDLE. `mem_done` is ignored in IDLE unless `mem_en=1` that cycle.
- Reset mid-BUSY: the request is abandoned. Next state is IDLE; a late `mem_done` arriving while IDLE with no op is ignored.

## Test plan
- **Same-cycle hit:** load, `ALU_out_is=0x0040`, `mem_done=1` in the issue cycle, `mem_rdata=0xBEEF`.
  - `mem_en` high for 1 cycle, `stall=0`, `mem_data_os=0xBEEF`, `stall_cnt=0`.
- **Multi-cycle store:** store of `0x1234` to `0x0010`, `mem_done` arrives 3 cycles after issue.
  - `mem_en` high only in the issue cycle.
  - `stall` high 3 cycles, low in the done cycle; `reg_w_en_os=0` while stalled.
  - `stall_cnt=3`.
- **Busy retry:** `mem_busy=1` for 2 cycles, then 0 with `mem_done=1`.
  - `mem_en` high for 3 consecutive cycles, `stall` high for 2 cycles, one access completes.
- **Dump after op:** `createdump_is=1` together with a 2-cycle load.
  - Load completes; `mem_dump` pulses exactly once in the next cycle.
  - `halted=1` and `stall=1` thereafter.
- **Reset in BUSY:** assert `rst` on the second BUSY cycle.
  - Next cycle: IDLE, `stall_cnt=0`, `stall=0`.
  - A stray `mem_done` afterwards leaves `rd_q` unchanged.
- **Counter saturation:** force more than 65535 stall cycles (preload via long BUSY).
  - `stall_cnt` holds at 0xFFFF.
